// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit asynchronous serial receiver with valid/ready output handshake.
//   Frame: start(0), 8 data bits LSB first, [even parity bit], stop(1).
//   Optional feature macro: UART_RX_PARITY_EN (defined -> parity bit expected and checked).
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   rx_data    last accepted byte
//   rx_valid   rx_data/frame_err/parity_err hold an unconsumed frame
//   rx_ready   consumer accepts the frame when rx_valid && rx_ready
//   frame_err  stop bit of the held frame sampled low
//   parity_err parity check of the held frame failed (0 when parity compiled out)
//   overrun    one-cycle pulse when a completed frame is dropped
module uart_receiver #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int unsigned BIT_DELAY  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_DELAY = BIT_DELAY / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_DELAY + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DELAY - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic             rx_s1;
  logic             rx_sync;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             frame_par_err_c;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign frame_par_err_c = (^shift_reg) ^ par_bit;
`else
  assign frame_par_err_c = 1'b0;
`endif

  // Synchronizer, receive FSM and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
      overrun <= 1'b0;

      // Handshake clears valid; a frame completing this same cycle overrides below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            state   <= S_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end

        // Recheck the line at the middle of the start bit to reject glitches.
        S_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            par_bit <= rx_sync;
            state   <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        // Frame completes here; a held, unconsumed frame wins over the new one.
        S_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= rx_sync ? S_IDLE : S_WAIT_IDLE;
            if (!rx_valid || rx_ready) begin
              rx_data    <= shift_reg;
              frame_err  <= ~rx_sync;
              parity_err <= frame_par_err_c;
              rx_valid   <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // A low line after a bad stop bit (break) must not start a new frame.
        S_WAIT_IDLE: begin
          if (rx_sync) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver with CLK_FREQ=16, BAUD_RATE=1.
//   Follows the UART_RX_PARITY_EN macro so the same bench covers both frame formats.
module tb_uart_receiver;

  localparam int unsigned BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_seen = 0;

  // Reference model: what the consumer should currently be holding.
  logic       exp_valid;
  logic [7:0] exp_data;
  logic       exp_ferr;
  logic       exp_perr;
  int         exp_ovr;

  uart_receiver #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Count high cycles of overrun; a one-cycle pulse per drop keeps this equal to drops.
  always @(negedge clk) if (overrun === 1'b1) ovr_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(rx_valid), 32'(exp_valid));
    if (exp_valid) begin
      check({tag, ".data"}, 32'(rx_data), 32'(exp_data));
      check({tag, ".ferr"}, 32'(frame_err), 32'(exp_ferr));
      check({tag, ".perr"}, 32'(parity_err), 32'(exp_perr));
    end
    check({tag, ".ovr"}, 32'(ovr_seen), 32'(exp_ovr));
  endtask

  task automatic drive_bit(input logic b, input int ncyc);
    rx = b;
    repeat (ncyc) @(negedge clk);
  endtask

  // Send a complete frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    if (PAR_EN) drive_bit(par, BIT_CLKS);
    drive_bit(stop, BIT_CLKS);
  endtask

  // Model of what a completed frame does to the held output.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    if (exp_valid) begin
      exp_ovr++;
    end else begin
      exp_valid = 1'b1;
      exp_data  = d;
      exp_ferr  = ~stop;
      exp_perr  = PAR_EN ? ((^d) ^ par) : 1'b0;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic par, input logic stop);
    send_frame(d, par, stop);
    model_frame(d, par, stop);
    check_outputs(tag);
  endtask

  task automatic consume(input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    exp_valid = 1'b0;
    check({tag, ".cleared"}, 32'(rx_valid), 32'(0));
  endtask

  task automatic idle(input int ncyc);
    drive_bit(1'b1, ncyc);
  endtask

  initial begin
    logic [7:0] d;
    logic       par;
    logic       stop;

    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    exp_valid = 1'b0; exp_data = '0; exp_ferr = 1'b0; exp_perr = 1'b0; exp_ovr = 0;
    repeat (3) @(negedge clk);
    check("reset.data", 32'(rx_data), 32'(0));
    check("reset.valid", 32'(rx_valid), 32'(0));
    check("reset.flags", 32'({frame_err, parity_err, overrun}), 32'(0));
    rst = 1'b0;
    idle(10);

    // Good frame held until consumed.
    frame("a5", 8'hA5, 1'b0, 1'b1);
    idle(30);
    check_outputs("a5.hold");
    consume("a5");

    // Wrong parity bit (only checked when parity is present).
    idle(10);
    frame("01", 8'h01, 1'b0, 1'b1);
    consume("01");

    // Bad stop bit followed by a long low line: no retrigger.
    idle(10);
    frame("3c", 8'h3C, 1'b0, 1'b0);
    consume("3c");
    drive_bit(1'b0, 3 * BIT_CLKS);
    check("break.novalid", 32'(rx_valid), 32'(0));
    idle(20);
    check("break.idle", 32'(rx_valid), 32'(0));

    // False start: short low pulse.
    drive_bit(1'b0, 4);
    idle(40);
    check("glitch.novalid", 32'(rx_valid), 32'(0));

    // Overrun: second frame dropped while first is held.
    frame("11", 8'h11, 1'b0, 1'b1);
    idle(5);
    frame("22", 8'h22, 1'b0, 1'b1);
    idle(10);
    check_outputs("22.held11");
    consume("11");

    // Reset in the middle of bit 3 abandons the frame.
    idle(10);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h55 >> i), BIT_CLKS);
    drive_bit(1'b0, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_valid = 1'b0;
    idle(8 * BIT_CLKS);
    check("rst.novalid", 32'(rx_valid), 32'(0));
    check("rst.data", 32'(rx_data), 32'(0));
    frame("66", 8'h66, 1'b0, 1'b1);
    consume("66");
    idle(10);

    // Randomized frames with random consumer behaviour.
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      par  = (^d) ^ ($urandom_range(3) == 0);
      stop = ($urandom_range(5) != 0);
      frame($sformatf("rnd%0d", n), d, par, stop);
      if (!stop) drive_bit(1'b0, $urandom_range(40, 5));
      idle($urandom_range(30, 10));
      if ($urandom_range(2) != 0) consume($sformatf("rnd%0d", n));
    end
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate; BIT_DELAY = CLK_FREQ / BAUD_RATE clocks per bit, integer division.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, 8, last received byte.
REQ-007 SHALL have port rx_valid, output, 1, rx_data and status flags hold a frame not yet consumed.
REQ-008 SHALL have port rx_ready, input, 1, consumer accepts the frame on a cycle where rx_valid=1 and rx_ready=1.
REQ-009 SHALL have port frame_err, output, 1, stop bit of the held frame was sampled low.
REQ-010 SHALL have port parity_err, output, 1, parity check of the held frame failed.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL accept frames: start bit (0), 8 data bits LSB first, parity bit (see REQ-030), one stop bit (1).
REQ-014 SHALL implement states S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE.
REQ-015 S_IDLE: synchronized rx low -> S_START, bit counter cleared, clock counter cleared.
REQ-016 S_START: after BIT_DELAY/2 clocks, rx low -> S_DATA; rx high -> S_IDLE (false start, nothing reported).
REQ-017 S_DATA: sample rx every BIT_DELAY clocks (bit centres); shift into byte LSB first; after 8th sample -> S_PARITY, or S_STOP when parity compiled out.
REQ-018 S_PARITY: sample after BIT_DELAY clocks; parity_err for the frame = (XOR of 8 data bits) XOR sampled bit (even parity).
REQ-019 S_STOP: sample after BIT_DELAY clocks; rx=1 -> S_IDLE; rx=0 -> frame_err for the frame, -> S_WAIT_IDLE.
REQ-020 S_WAIT_IDLE: remain until synchronized rx high, then -> S_IDLE; prevents break/low line retriggering.
REQ-021 On the stop-sample edge with rx_valid=0, or rx_valid=1 and rx_ready=1 that same cycle: load rx_data, frame_err, parity_err and set rx_valid=1 (visible next cycle).
REQ-022 On the stop-sample edge with rx_valid=1 and rx_ready=0: drop new frame, hold old rx_data/flags, pulse overrun high for exactly one cycle.
REQ-023 rx_valid SHALL clear the cycle after a handshake with no simultaneous frame completion.
REQ-024 rx_data, frame_err, parity_err SHALL remain stable while rx_valid=1.
REQ-025 Clock counter width SHALL be $clog2(BIT_DELAY+1); counter resets to 0 on every sample.
REQ-026 Framed bytes with errors SHALL still be delivered with the corresponding flag set.

Reset
REQ-027 rst=1 SHALL force state S_IDLE, counters 0, synchronizer flops 1, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0 on the next edge.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no report; after release, reception restarts on the next falling edge.
REQ-029 Reset SHALL take precedence over rx_ready and rx activity in the same cycle.

Configuration
REQ-030 Macro UART_RX_PARITY_EN: defined -> S_PARITY present, parity bit expected and checked (11-bit frame); undefined -> S_PARITY removed, 10-bit frame, parity_err tied 0.

Verification
REQ-031 Benches SHALL use CLK_FREQ=16, BAUD_RATE=1 (BIT_DELAY=16), parity enabled unless stated.
REQ-032 Send 0xA5 with parity 0, stop 1, rx_ready=0 -> rx_valid=1, rx_data=0xA5, frame_err=0, parity_err=0; stays until rx_ready=1, then clears next cycle.
REQ-033 Send 0x01 with parity bit 0 -> rx_data=0x01, parity_err=1; send 0x3C with stop bit 0 -> frame_err=1, no new frame until rx returns high.
REQ-034 rx low for 4 clocks then high -> no rx_valid, state returns S_IDLE.
REQ-035 Send 0x11 then 0x22 with rx_ready=0 throughout -> rx_data stays 0x11, overrun pulses one cycle at second stop sample.
REQ-036 Assert rst during bit 3 of 0x55, then send 0x66 -> only 0x66 reported; rebuild without UART_RX_PARITY_EN, send 0x66 as 10-bit frame -> rx_data=0x66, parity_err=0.
